// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and address helpers for the LAB7 data-cache
// controller.
//   ADDR_W / DATA_W : byte-address and word widths (32)
//   INDEX_W         : cache index width, 512 direct-mapped one-word lines
//   TAG_W           : ADDR_W - INDEX_W - 2 = 21
//   state_e         : controller states IDLE / RD_MEM / WR_MEM
//   tag_of, idx_of  : address-field extraction (tag=[31:11], index=[10:2])
package dcache_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int INDEX_W = 9;
  localparam int TAG_W   = ADDR_W - INDEX_W - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_MEM = 2'd1,
    WR_MEM = 2'd2
  } state_e;

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] idx_of(input logic [ADDR_W-1:0] addr);
    return addr[INDEX_W+1:2];
  endfunction

endpackage

// File: rtl/dcache_ctrl_sat_counter32.sv
// sat_counter32: 32-bit event counter that sticks at all-ones.
//   clk   : clock, updates on posedge
//   rst   : synchronous active-high clear
//   inc   : count one event this cycle
//   count : current count
module sat_counter32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: control stage of the direct-mapped, one-word-block,
// write-through / no-write-allocate data cache of the LAB7 MIPS pipeline.
// Widths come from dcache_pkg (ADDR_W=32, DATA_W=32, INDEX_W=9, TAG_W=21).
//   clk, rst                   : clock (posedge) and synchronous active-high reset
//   cpu_req/we/addr/wdata      : MEM-stage access; cpu_rdata, cpu_stall back to pipe
//   idx                        : index shared by the valid/tag/data arrays
//   valid_in/tag_in/data_in    : combinational array read data
//   *_wr / *_din               : array write enables and data (arrays write on negedge)
//   mem_req/we/addr/wdata      : main-memory request; mem_rdata, mem_ack (1-cycle pulse)
//   hit_cnt / miss_cnt         : saturating load hit / miss counters
//
// States:
//   IDLE   | accepting requests; load hits return with zero latency
//   RD_MEM | load miss: reading main memory, refill on ack
//   WR_MEM | store: write-through to main memory, wait for ack
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic               cpu_stall,
  output logic [INDEX_W-1:0] idx,
  input  logic               valid_in,
  output logic               valid_wr,
  output logic               valid_din,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               tag_wr,
  output logic [TAG_W-1:0]   tag_din,
  input  logic [DATA_W-1:0]  data_in,
  output logic               data_wr,
  output logic [DATA_W-1:0]  data_din,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
);

  state_e             r_state;
  state_e             w_next_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [ADDR_W-1:0]  w_cur_addr;
  logic               w_hit;
  logic               w_hit_inc;
  logic               w_miss_inc;

  // In IDLE the arrays are looked up with the live address so a load hit
  // completes in the same cycle; afterwards the latched address is used,
  // which makes the pipeline free to change cpu_addr while stalled.
  assign w_cur_addr = (r_state == IDLE) ? cpu_addr : r_addr;
  assign idx        = idx_of(w_cur_addr);
  assign w_hit      = valid_in && (tag_in == tag_of(w_cur_addr));

  assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = r_wdata;
  assign tag_din    = tag_of(r_addr);
  assign valid_din  = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == IDLE) && cpu_req) begin
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    cpu_rdata    = '0;
    cpu_stall    = 1'b0;
    valid_wr     = 1'b0;
    tag_wr       = 1'b0;
    data_wr      = 1'b0;
    data_din     = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    w_hit_inc    = 1'b0;
    w_miss_inc   = 1'b0;

    // Reset holds every control output inactive so the self-clearing valid
    // array is never written and main memory sees no request.
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          if (cpu_req) begin
            if (!cpu_we) begin
              if (w_hit) begin
                cpu_rdata = data_in;
                w_hit_inc = 1'b1;
              end else begin
                cpu_stall    = 1'b1;
                w_miss_inc   = 1'b1;
                w_next_state = RD_MEM;
              end
            end else begin
              // No write-allocate: only an existing line is updated.
              cpu_stall    = 1'b1;
              w_next_state = WR_MEM;
              if (w_hit) begin
                data_wr  = 1'b1;
                data_din = cpu_wdata;
              end
            end
          end
        end

        RD_MEM: begin
          mem_req   = 1'b1;
          cpu_stall = 1'b1;
          if (mem_ack) begin
            valid_wr     = 1'b1;
            tag_wr       = 1'b1;
            data_wr      = 1'b1;
            data_din     = mem_rdata;
            cpu_rdata    = mem_rdata;
            cpu_stall    = 1'b0;
            w_next_state = IDLE;
          end
        end

        WR_MEM: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          cpu_stall = 1'b1;
          if (mem_ack) begin
            cpu_stall    = 1'b0;
            w_next_state = IDLE;
          end
        end

        default: w_next_state = IDLE;
      endcase
    end
  end

  sat_counter32 u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_hit_inc),
    .count (hit_cnt)
  );

  sat_counter32 u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_miss_inc),
    .count (miss_cnt)
  );

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl. The cache arrays and
// main memory are modelled around the DUT; expected load data, hit/miss and
// counter values come from a reference model of memory and line ownership.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               cpu_req, cpu_we;
  logic [ADDR_W-1:0]  cpu_addr;
  logic [DATA_W-1:0]  cpu_wdata, cpu_rdata;
  logic               cpu_stall;
  logic [INDEX_W-1:0] idx;
  logic               valid_in, valid_wr, valid_din;
  logic [TAG_W-1:0]   tag_in, tag_din;
  logic               tag_wr;
  logic [DATA_W-1:0]  data_in, data_din;
  logic               data_wr;
  logic               mem_req, mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata, mem_rdata;
  logic               mem_ack;
  logic [31:0]        hit_cnt, miss_cnt;

  dcache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .idx(idx),
    .valid_in(valid_in), .valid_wr(valid_wr), .valid_din(valid_din),
    .tag_in(tag_in), .tag_wr(tag_wr), .tag_din(tag_din),
    .data_in(data_in), .data_wr(data_wr), .data_din(data_din),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input bit ok,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic finish_sim();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  // ---------------- cache arrays (write on negedge, valid cleared by rst)
  logic              valid_arr [512];
  logic [TAG_W-1:0]  tag_arr   [512];
  logic [DATA_W-1:0] data_arr  [512];

  assign valid_in = valid_arr[idx];
  assign tag_in   = tag_arr[idx];
  assign data_in  = data_arr[idx];

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) valid_arr[i] <= 1'b0;
    end else begin
      if (valid_wr) valid_arr[idx] <= valid_din;
      if (tag_wr)   tag_arr[idx]   <= tag_din;
      if (data_wr)  data_arr[idx]  <= data_din;
    end
  end

  // ---------------- memories: environment and reference
  logic [31:0] env_mem [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  function automatic logic [29:0] waddr(input logic [31:0] a);
    return a[31:2];
  endfunction

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return {w[13:0], w[17:0]} ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] env_rd(input logic [29:0] w);
    if (env_mem.exists(w)) return env_mem[w];
    return init_word(w);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return init_word(w);
  endfunction

  // ---------------- main-memory responder
  int          resp_delay = -1;
  bit          resp_en    = 1'b1;
  int          resp_cnt   = -1;
  logic [31:0] cur_addr   = '0;
  logic [31:0] cur_wdata  = '0;
  logic        cur_we     = 1'b0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (resp_en) begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
      if (rst || !mem_req || !resp_en) begin
        resp_cnt = -1;
      end else begin
        if (resp_cnt < 0) resp_cnt = (resp_delay >= 0) ? resp_delay : int'($urandom_range(0, 3));
        else resp_cnt--;
        if (resp_cnt == 0) begin
          check("mem_addr", mem_addr == {cur_addr[31:2], 2'b00}, mem_addr, {cur_addr[31:2], 2'b00});
          check("mem_we", mem_we == cur_we, 32'(mem_we), 32'(cur_we));
          if (cur_we) begin
            check("mem_wdata", mem_wdata == cur_wdata, mem_wdata, cur_wdata);
            env_mem[waddr(mem_addr)] = mem_wdata;
          end else begin
            mem_rdata = env_rd(waddr(mem_addr));
          end
          mem_ack  = 1'b1;
          resp_cnt = -1;
        end
      end
    end
  end

  // ---------------- scoreboard + monitor
  typedef struct packed {
    logic        is_load;
    logic        hit;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   stall_cnt = 0;
  int   last_lat  = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0;
      end else if (cpu_req) begin
        if (cpu_stall) begin
          stall_cnt++;
        end else begin
          if (sb_q.size() == 0) begin
            check("unexpected_completion", 1'b0, cpu_rdata, 32'h0);
          end else begin
            e = sb_q.pop_front();
            if (e.is_load) begin
              check("load_data", cpu_rdata == e.data, cpu_rdata, e.data);
              if (e.hit) check("hit_latency", stall_cnt == 0, 32'(stall_cnt), 32'd0);
              else       check("miss_latency", stall_cnt >= 1, 32'(stall_cnt), 32'd1);
            end else begin
              check("store_latency", stall_cnt >= 1, 32'(stall_cnt), 32'd1);
            end
          end
          last_lat  = stall_cnt;
          stall_cnt = 0;
        end
      end
    end
  end

  // ---------------- reference model state
  bit               ref_valid [512];
  logic [TAG_W-1:0] ref_tag   [512];
  logic [31:0]      ref_hit, ref_miss;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 512; i++) ref_valid[i] = 1'b0;
    ref_hit  = '0;
    ref_miss = '0;
  endtask

  // Issues one access and holds it until the DUT completes it. Inputs are
  // scrambled while stalled; a correct controller ignores them.
  task automatic do_access(input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, input int dly);
    exp_t             e;
    logic [8:0]       ix;
    logic [TAG_W-1:0] tg;
    bit               done;
    ix = addr[10:2];
    tg = addr[31:11];
    e.is_load = !we;
    e.hit     = ref_valid[ix] && (ref_tag[ix] == tg);
    e.data    = ref_rd(waddr(addr));
    if (!we) begin
      if (e.hit) ref_hit = sat_inc(ref_hit);
      else begin
        ref_miss      = sat_inc(ref_miss);
        ref_valid[ix] = 1'b1;
        ref_tag[ix]   = tg;
      end
    end else begin
      ref_mem[waddr(addr)] = wd;
    end
    @(posedge clk); #1;
    sb_q.push_back(e);
    cur_addr   = addr;
    cur_we     = we;
    cur_wdata  = wd;
    resp_delay = dly;
    cpu_req    = 1'b1;
    cpu_we     = we;
    cpu_addr   = addr;
    cpu_wdata  = wd;
    done       = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!cpu_stall) done = 1'b1;
      else begin
        @(posedge clk); #1;
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
        cpu_we    = 1'($urandom_range(0, 1));
      end
    end
    if (!done) begin
      check("access_timeout", 1'b0, addr, 32'h0);
      finish_sim();
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    cpu_req  = 1'b0;
    cpu_addr = $urandom;
    cpu_we   = 1'($urandom_range(0, 1));
  endtask

  task automatic check_counters(input string tag);
    idle_cycle();
    check({tag, "_hit_cnt"},  hit_cnt  == ref_hit,  hit_cnt,  ref_hit);
    check({tag, "_miss_cnt"}, miss_cnt == ref_miss, miss_cnt, ref_miss);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst       = 1'b1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h0000_0100;
    cpu_wdata = '0;
    ref_reset();
    env_mem[waddr(32'h0000_0100)] = 32'hDEAD_BEEF;
    ref_mem[waddr(32'h0000_0100)] = 32'hDEAD_BEEF;

    // reset: outputs forced inactive even with a pending load miss
    repeat (3) @(negedge clk);
    check("rst_stall",   cpu_stall == 1'b0, 32'(cpu_stall), 32'd0);
    check("rst_mem_req", mem_req == 1'b0, 32'(mem_req), 32'd0);
    check("rst_mem_we",  mem_we == 1'b0, 32'(mem_we), 32'd0);
    check("rst_arr_wr",  {valid_wr, tag_wr, data_wr} == 3'b000, 32'({valid_wr, tag_wr, data_wr}), 32'd0);
    check("rst_rdata",   cpu_rdata == 32'h0, cpu_rdata, 32'h0);
    @(posedge clk); #1;
    rst     = 1'b0;
    cpu_req = 1'b0;
    check("rst_hit_cnt",  hit_cnt == 32'h0, hit_cnt, 32'h0);
    check("rst_miss_cnt", miss_cnt == 32'h0, miss_cnt, 32'h0);

    // cold load, ack three cycles after entering RD_MEM
    do_access(1'b0, 32'h0000_0100, '0, 3);
    check_counters("cold");
    check("cold_stall_cycles", last_lat == 4, 32'(last_lat), 32'd4);
    check("cold_valid", valid_arr[9'h040] == 1'b1, 32'(valid_arr[9'h040]), 32'd1);
    check("cold_tag",   tag_arr[9'h040] == 21'h0, 32'(tag_arr[9'h040]), 32'h0);
    check("cold_data",  data_arr[9'h040] == 32'hDEAD_BEEF, data_arr[9'h040], 32'hDEAD_BEEF);

    // hit after fill
    do_access(1'b0, 32'h0000_0100, '0, -1);
    check_counters("hit");
    check("hit_zero_stall", last_lat == 0, 32'(last_lat), 32'd0);
    check("hit_cnt_1", hit_cnt == 32'd1, hit_cnt, 32'd1);

    // conflict misses on index 0x040
    do_access(1'b0, 32'h0000_0900, '0, -1);
    check_counters("conflict1");
    check("conflict_tag", tag_arr[9'h040] == 21'h1, 32'(tag_arr[9'h040]), 32'h1);
    do_access(1'b0, 32'h0000_0100, '0, -1);
    check_counters("conflict2");
    check("miss_cnt_3", miss_cnt == 32'd3, miss_cnt, 32'd3);

    // refill with the earliest possible ack
    do_access(1'b0, 32'h0000_0900, '0, 0);
    check_counters("early_ack");
    check("early_ack_stall", last_lat == 1, 32'(last_lat), 32'd1);

    // store hit: array updated, write-through to memory
    do_access(1'b1, 32'h0000_0900, 32'h1234_5678, 2);
    check_counters("sw_hit");
    check("sw_hit_data",  data_arr[9'h040] == 32'h1234_5678, data_arr[9'h040], 32'h1234_5678);
    check("sw_hit_stall", last_lat == 3, 32'(last_lat), 32'd3);

    // store miss: no allocate, then back-to-back loads miss then hit
    do_access(1'b1, 32'h0000_2000, 32'hCAFE_F00D, -1);
    check_counters("sw_miss");
    check("sw_miss_valid", valid_arr[9'h000] == 1'b0, 32'(valid_arr[9'h000]), 32'd0);
    do_access(1'b0, 32'h0000_2000, '0, -1);
    do_access(1'b0, 32'h0000_2000, '0, -1);
    check_counters("b2b");

    // hit counter saturation
    @(posedge clk); #1;
    cpu_req = 1'b0;
    force dut.u_hit_cnt.r_count = 32'hFFFF_FFFE;
    #1;
    release dut.u_hit_cnt.r_count;
    ref_hit = 32'hFFFF_FFFE;
    repeat (3) do_access(1'b0, 32'h0000_0900, '0, -1);
    check_counters("sat");
    check("hit_cnt_sat", hit_cnt == 32'hFFFF_FFFF, hit_cnt, 32'hFFFF_FFFF);

    // reset in the second RD_MEM cycle, then a stray ack in IDLE
    resp_en = 1'b0;
    @(posedge clk); #1;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0300;
    @(posedge clk); #1;
    check("abort_req_rd0", mem_req == 1'b1, 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_mem_req", mem_req == 1'b0, 32'(mem_req), 32'd0);
    check("abort_stall",   cpu_stall == 1'b0, 32'(cpu_stall), 32'd0);
    check("abort_arr_wr",  {valid_wr, tag_wr, data_wr} == 3'b000, 32'({valid_wr, tag_wr, data_wr}), 32'd0);
    @(posedge clk); #1;
    rst     = 1'b0;
    cpu_req = 1'b0;
    check("abort_idle_req", mem_req == 1'b0, 32'(mem_req), 32'd0);
    check("abort_hit_cnt",  hit_cnt == 32'h0, hit_cnt, 32'h0);
    check("abort_miss_cnt", miss_cnt == 32'h0, miss_cnt, 32'h0);
    @(posedge clk); #1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    #1;
    check("stray_ack_req",   mem_req == 1'b0, 32'(mem_req), 32'd0);
    check("stray_ack_valid", valid_arr[9'h0C0] == 1'b0, 32'(valid_arr[9'h0C0]), 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("stray_ack_ignored", mem_req == 1'b0 && cpu_stall == 1'b0, 32'({mem_req, cpu_stall}), 32'd0);
    ref_reset();
    resp_en = 1'b1;
    do_access(1'b0, 32'h0000_0300, '0, -1);
    do_access(1'b0, 32'h0000_0100, '0, -1);
    check_counters("post_abort");
    check("post_abort_miss_cnt", miss_cnt == 32'd2, miss_cnt, 32'd2);

    // randomized traffic over a small set of conflicting lines
    for (int n = 0; n < 300; n++) begin
      a = (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 7)) << 2)
        | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) do_access(1'b1, a, $urandom, -1);
      else                           do_access(1'b0, a, '0, -1);
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end
    check_counters("random");
    check("sb_drained", sb_q.size() == 0, 32'(sb_q.size()), 32'd0);

    finish_sim();
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Control stage for the direct-mapped, one-word-block data cache of the LAB7 pipelined MIPS.
- Sits between the MEM pipeline stage and main memory.
- Drives the cache arrays: the valid-bit array (512 entries, flash-cleared by rst), the tag array and the data array.
- Reads the arrays combinationally, decides hit/miss, runs write-through / read-refill handshakes with main memory, and stalls the pipeline.

Parameters:
- ADDR_W, 32: byte address width.
- DATA_W, 32: word width.
- INDEX_W, 9: cache index width (512 lines).
- TAG_W, ADDR_W-INDEX_W-2 (21): tag width. Address split is tag=[31:11], index=[10:2]; [1:0] ignored.

Ports:
- clk  in  1  clock; state updates on posedge. Arrays write on negedge of the same cycle the enable is high.
- rst  in  1  reset, synchronous, active-high.
- cpu_req  in  1  MEM-stage access valid.
- cpu_we  in  1  1=store (sw), 0=load (lw).
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data.
- cpu_stall  out  1  freeze pipeline.
- idx  out  INDEX_W  array index, shared by all three arrays.
- valid_in  in  1  valid-array read data.
- valid_wr  out  1  valid-array write enable.
- valid_din  out  1  valid-array write data.
- tag_in  in  TAG_W  tag-array read data.
- tag_wr  out  1  tag-array write enable.
- tag_din  out  TAG_W  tag-array write data.
- data_in  in  DATA_W  data-array read data.
- data_wr  out  1  data-array write enable.
- data_din  out  DATA_W  data-array write data.
- mem_req  out  1  main-memory request.
- mem_we  out  1  main-memory write.
- mem_addr  out  ADDR_W  word-aligned ({addr[31:2],2'b00}).
- mem_wdata  out  DATA_W  main-memory write data.
- mem_rdata  in  DATA_W  main-memory read data.
- mem_ack  in  1  main-memory done, one-cycle pulse.
- hit_cnt  out  32  load hits, saturating.
- miss_cnt  out  32  load misses, saturating.

Behaviour:
- Reset:
  - rst sampled at posedge: state=IDLE, latched addr/wdata=0, hit_cnt=miss_cnt=0.
  - While rst=1, all outputs are forced combinationally: cpu_stall=0, mem_req=0, mem_we=0, valid_wr=tag_wr=data_wr=0, cpu_rdata=0.
  - Valid array clears itself during rst; controller must not write during rst.
- Hit: hit = valid_in & (tag_in == addr tag), evaluated combinationally on idx.
- idx source: IDLE uses cpu_addr[10:2]; other states use the latched address.
- FSM states: IDLE, RD_MEM, WR_MEM.
- IDLE:
  - cpu_req=0: no action, stall=0.
  - Load hit: cpu_rdata=data_in, stall=0, hit_cnt+1, stay IDLE (zero-latency).
  - Load miss: stall=1, latch addr, miss_cnt+1, go RD_MEM.
  - Store: stall=1, latch addr/wdata, go WR_MEM.
    - On hit, same cycle: data_wr=1, data_din=cpu_wdata (valid/tag unchanged).
    - On miss: no allocate; arrays untouched.
- RD_MEM:
  - mem_req=1, mem_we=0, stall=1.
  - On mem_ack (sampled this cycle):
    - valid_wr=tag_wr=data_wr=1; valid_din=1, tag_din=latched tag, data_din=mem_rdata.
    - cpu_rdata=mem_rdata, stall=0.
    - Next state IDLE.
- WR_MEM:
  - mem_req=1, mem_we=1, mem_wdata=latched wdata, stall=1.
  - On mem_ack: stall=0, next state IDLE.
- Miss latency: a miss costs N+1 cycles if ack arrives N cycles after entry.
- Boundary conditions:
  - Earliest ack is the first cycle in RD_MEM/WR_MEM.
  - mem_ack in IDLE is ignored.
  - cpu_req/cpu_addr changes while not in IDLE are ignored.
  - The cycle after completion is IDLE and resamples cpu_req.
  - Load to the just-filled line in the next cycle must hit.
  - rst mid RD_MEM/WR_MEM: FSM to IDLE, mem_req drops the same cycle, no array write, no counter change.
  - Counters saturate at 32'hFFFFFFFF; stores are not counted.
- Conflict miss: a fill to the same index with a different tag overwrites the tag; the old line is lost.

Decomposition:
- Shared package dcache_pkg:
  - State enum {IDLE, RD_MEM, WR_MEM}.
  - INDEX_W/TAG_W constants.
  - Address-field extract functions (tag_of, idx_of).
- One natural sub-module: sat_counter32 (inc, rst, count), instantiated twice.
- FSM and datapath stay in dcache_ctrl.

Test Plan:
- Cold load: rst, then lw 0x0000_0100, mem_ack after 3 cycles with 0xDEADBEEF -> stall for 4 cycles; valid/tag/data written at idx 0x040; cpu_rdata=0xDEADBEEF; miss_cnt=1.
- Hit after fill: repeat lw 0x0000_0100 -> stall=0 same cycle, cpu_rdata=0xDEADBEEF, hit_cnt=1.
- Conflict miss: lw 0x0000_0900 (same idx 0x040, tag 1) -> miss, refill overwrites tag; then lw 0x0000_0100 -> miss again; miss_cnt=3.
- Stores, both hit and miss cases:
  - sw 0x0000_0900 with 0x12345678 (hit) -> data_wr in IDLE cycle; mem_req & mem_we until ack; mem_addr=0x0000_0900.
  - sw 0x0000_2000 (miss) -> write-through only, valid array unchanged.
- Reset mid-refill: lw miss, assert rst in 2nd RD_MEM cycle -> mem_req=0, state IDLE, counters 0; a later ack pulse is ignored; subsequent lw misses.
- Counter saturation: force hit_cnt to 32'hFFFFFFFE, issue 3 load hits -> hit_cnt=32'hFFFFFFFF.
